// File: rtl/serial_feeder_pkg.sv
// Shared types and constants for the serial bit feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_feeder_pkg;

    // Feeder FSM: IDLE emits forced zeros, SHIFT presents frame bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; must hold WIDTH-1, and never drops below one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-in, serial-out feeder: WIDTH-bit words become one bit per clock for the 101 detector.
// Latency: word accepted at edge k shows bit i after edge k+1+i; frame_done with the last bit.
// Backpressure: data_ready drops while the one-word holding register is full or R is high.
//
// Ports:
//   clk, R          clock and synchronous active-high reset
//   data_in/_valid  word input, transferred when data_valid && data_ready at an edge
//   data_ready      holding register empty and not in reset
//   out_bit         serial stream (forced 0 in IDLE), drives the detector's input
//   bit_valid       out_bit carries a frame bit
//   frame_done      cycle presenting the last bit of a frame
//   busy            shifter active or holding register full
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out_bit,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic accept;
    logic last_bit;
    logic load;

    assign data_ready = !hold_full_q && !R;
    assign accept     = data_valid && data_ready;
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // Loading on the last-bit edge is what makes back-to-back frames gapless.
    // Accept and load are mutually exclusive: one needs hold empty, the other full.
    assign load       = hold_full_q && ((state_q == IDLE) || last_bit);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        if (load) begin
            shreg_d     = hold_q;
            cnt_d       = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
        end
    end

    // All outputs decode registered state only, so they move on clock edges.
    always_comb begin
        out_bit = 1'b0;
        if (state_q == SHIFT) begin
            out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end

    assign bit_valid  = (state_q == SHIFT);
    assign frame_done = last_bit;
    assign busy       = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: vector table plus directed multi-cycle sequences.
// Latency: n/a.
// Backpressure: exercised by changing data_in while data_ready is low.
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r;

    // Main instance: WIDTH=8, MSB first
    logic       m_dv;
    logic [7:0] m_din;
    logic       m_rdy, m_out, m_bv, m_fd, m_busy;

    // WIDTH=8, LSB first
    logic       l_dv;
    logic [7:0] l_din;
    logic       l_rdy, l_out, l_bv, l_fd, l_busy;

    // WIDTH=2, LSB first
    logic       t_dv;
    logic [1:0] t_din;
    logic       t_rdy, t_out, t_bv, t_fd, t_busy;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_main (
        .clk(clk), .R(r), .data_in(m_din), .data_valid(m_dv), .data_ready(m_rdy),
        .out_bit(m_out), .bit_valid(m_bv), .frame_done(m_fd), .busy(m_busy)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .R(r), .data_in(l_din), .data_valid(l_dv), .data_ready(l_rdy),
        .out_bit(l_out), .bit_valid(l_bv), .frame_done(l_fd), .busy(l_busy)
    );

    serial_bit_feeder #(.WIDTH(2), .MSB_FIRST(1'b0)) u_w2 (
        .clk(clk), .R(r), .data_in(t_din), .data_valid(t_dv), .data_ready(t_rdy),
        .out_bit(t_out), .bit_valid(t_bv), .frame_done(t_fd), .busy(t_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {r, data_valid, data_in, expected {out_bit, bit_valid, frame_done, busy, data_ready}}
    typedef struct packed {
        logic       r;
        logic       dv;
        logic [7:0] din;
        logic [4:0] exp;
    } vec_t;

    vec_t vt[14];

    logic cap_bit[64];
    logic cap_bv[64];
    logic cap_fd[64];
    int   cap_n;

    // Feed n words on the main instance, holding data_valid high until all are taken.
    // With garble set, data_in is scrambled whenever data_ready is low.
    task automatic run_words(input logic [7:0] w[4], input int n, input bit garble, input int cycles);
        int  idx;
        logic acc;
        idx   = 0;
        cap_n = 0;
        for (int c = 0; c < cycles && c < 64; c++) begin
            if (idx < n) begin
                m_dv  = 1'b1;
                m_din = (garble && !m_rdy) ? 8'($urandom) : w[idx];
            end else begin
                m_dv  = 1'b0;
                m_din = 8'($urandom);
            end
            acc = m_dv && m_rdy;
            tick();
            if (acc) idx++;
            cap_bit[c] = m_out;
            cap_bv[c]  = m_bv;
            cap_fd[c]  = m_fd;
            cap_n      = c + 1;
        end
        m_dv = 1'b0;
    endtask

    task automatic check_stream(input string name, input logic [63:0] exp_bits, input int nbits);
        int first;
        int nbv;
        int nfd;
        logic [63:0] gb, gv, gf, ef;
        first = -1; nbv = 0; nfd = 0;
        gb = '0; gv = '0; gf = '0; ef = '0;
        for (int c = 0; c < cap_n; c++) begin
            if (cap_bv[c]) begin
                nbv++;
                if (first < 0) first = c;
            end
            if (cap_fd[c]) nfd++;
        end
        chk({name, " first_bit_cycle"}, 64'(first), 64'd1);
        chk({name, " valid_count"}, 64'(nbv), 64'(nbits));
        chk({name, " frame_done_count"}, 64'(nfd), 64'(nbits / 8));
        if (first >= 0) begin
            for (int j = 0; j < nbits; j++) begin
                if (first + j < 64) begin
                    gb = {gb[62:0], cap_bit[first+j]};
                    gv = {gv[62:0], cap_bv[first+j]};
                    gf = {gf[62:0], cap_fd[first+j]};
                end
                ef = {ef[62:0], (j % 8 == 7)};
            end
        end
        chk({name, " bits"}, gb, exp_bits);
        chk({name, " no_gap"}, gv, (64'd1 << nbits) - 64'd1);
        chk({name, " frame_done_pos"}, gf, ef);
    endtask

    initial begin
        logic [2:0]  hist;
        int          n101;
        logic [7:0]  w[4];
        logic [63:0] gb, eb, gv;
        int          nfd;

        r = 1'b1;
        m_dv = 1'b0; m_din = 8'h00;
        l_dv = 1'b0; l_din = 8'h00;
        t_dv = 1'b0; t_din = 2'b00;

        // Reset, then one word of A5 with the idle tail
        vt[0]  = {1'b1, 1'b1, 8'hA5, 5'b00000};
        vt[1]  = {1'b1, 1'b1, 8'hA5, 5'b00000};
        vt[2]  = {1'b0, 1'b0, 8'h00, 5'b00001};
        vt[3]  = {1'b0, 1'b1, 8'hA5, 5'b00010};
        vt[4]  = {1'b0, 1'b0, 8'h5A, 5'b11011};
        vt[5]  = {1'b0, 1'b0, 8'h5A, 5'b01011};
        vt[6]  = {1'b0, 1'b0, 8'h5A, 5'b11011};
        vt[7]  = {1'b0, 1'b0, 8'h5A, 5'b01011};
        vt[8]  = {1'b0, 1'b0, 8'h5A, 5'b01011};
        vt[9]  = {1'b0, 1'b0, 8'h5A, 5'b11011};
        vt[10] = {1'b0, 1'b0, 8'h5A, 5'b01011};
        vt[11] = {1'b0, 1'b0, 8'h5A, 5'b11111};
        vt[12] = {1'b0, 1'b0, 8'h5A, 5'b00001};
        vt[13] = {1'b0, 1'b0, 8'h5A, 5'b00001};

        hist = 3'b000;
        n101 = 0;
        for (int i = 0; i < 14; i++) begin
            r     = vt[i].r;
            m_dv  = vt[i].dv;
            m_din = vt[i].din;
            tick();
            chk($sformatf("vec%0d {out,bv,fd,busy,rdy}", i),
                64'({m_out, m_bv, m_fd, m_busy, m_rdy}), 64'(vt[i].exp));
            hist = {hist[1:0], m_out};
            if (hist == 3'b101) n101++;
        end
        chk("single A5 detector 101 matches", 64'(n101), 64'd2);

        // Back-to-back frames with data_valid held
        w = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        run_words(w, 2, 1'b0, 24);
        check_stream("b2b", 64'hA53C, 16);

        // Backpressure: data_in scrambled while hold is full
        w = '{8'hA5, 8'h3C, 8'h5A, 8'h00};
        run_words(w, 3, 1'b1, 32);
        check_stream("bp", 64'hA53C5A, 24);

        // Mid-frame reset after 3 bits of FF
        m_dv = 1'b1; m_din = 8'hFF;
        tick();
        m_dv = 1'b0; m_din = 8'h00;
        tick(); tick(); tick();
        chk("mid 3rd bit {out,bv,fd}", 64'({m_out, m_bv, m_fd}), 64'b110);
        r = 1'b1;
        tick();
        chk("mid reset {out,bv,fd,busy,rdy}", 64'({m_out, m_bv, m_fd, m_busy, m_rdy}), 64'd0);
        r = 1'b0;
        nfd = 0;
        gv  = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            nfd += int'(m_fd);
            gv = {gv[62:0], m_bv};
        end
        chk("mid after reset frame_done count", 64'(nfd), 64'd0);
        chk("mid after reset bit_valid", gv, 64'd0);
        w = '{8'h81, 8'h00, 8'h00, 8'h00};
        run_words(w, 1, 1'b0, 12);
        check_stream("after reset 81", 64'h81, 8);

        // LSB first, word 01
        l_dv = 1'b1; l_din = 8'h01;
        tick();
        l_dv = 1'b0; l_din = 8'hFF;
        gb = '0; gv = '0; nfd = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            gb = {gb[62:0], l_out};
            gv = {gv[62:0], l_bv};
            nfd += int'(l_fd);
        end
        chk("lsb bits", gb, 64'h80);
        chk("lsb valid", gv, 64'hFF);
        chk("lsb frame_done count", 64'(nfd), 64'd1);
        tick();
        chk("lsb idle {out,bv,busy,rdy}", 64'({l_out, l_bv, l_busy, l_rdy}), 64'b0001);

        // WIDTH=2 stream of 2'b10 words, LSB first: 0,1,0,1,... with no gaps
        t_dv = 1'b1; t_din = 2'b10;
        tick();
        gb = '0; eb = '0; gv = '0; nfd = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            gb = {gb[62:0], t_out};
            eb = {eb[62:0], (c % 2 == 0)};
            gv = {gv[62:0], t_bv};
            nfd += int'(t_fd);
        end
        chk("w2 bits", gb, eb);
        chk("w2 no_gap", gv, 64'hFFF);
        chk("w2 frame_done count", 64'(nfd), 64'd6);
        t_dv = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("w2 drained {bv,busy,rdy}", 64'({t_bv, t_busy, t_rdy}), 64'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
